// File: rtl/mdc_pkg.sv
// Shared types and constants for the binary-GCD engine.
// Optional feature macro: MDC_CYCLE_CNT_EN (adds the cyc_o cycle counter).
package mdc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Worst-case number of CALC cycles for a WIDTH-bit operand pair.
    function automatic int calc_bound(input int width);
        return 2 * width;
    endfunction

endpackage

// File: rtl/mdc_step.sv
// One iteration of the binary (Stein) GCD reduction, purely combinational.
// Exactly one rule fires per call; eq flags that the pair has converged.
module mdc_step
    import mdc_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int KW    = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic [KW-1:0]    k,
    output logic [WIDTH-1:0] x_nxt,
    output logic [WIDTH-1:0] y_nxt,
    output logic [KW-1:0]    k_nxt,
    output logic             eq
);

    // Priority-ordered reduction: equal, both even, x even, y even, both odd.
    always_comb begin
        x_nxt = x;
        y_nxt = y;
        k_nxt = k;
        eq    = (x == y);
        if (eq) begin
            // converged; caller produces x << k
        end else if (!x[0] && !y[0]) begin
            x_nxt = x >> 1;
            y_nxt = y >> 1;
            k_nxt = k + KW'(1);
        end else if (!x[0]) begin
            x_nxt = x >> 1;
        end else if (!y[0]) begin
            y_nxt = y >> 1;
        end else if (x > y) begin
            // odd - odd is even, so the halving never drops a set bit
            x_nxt = (x - y) >> 1;
        end else begin
            y_nxt = (y - x) >> 1;
        end
    end

endmodule

// File: rtl/mdc_engine.sv
// Multi-cycle binary GCD engine: IDLE -> CALC (one reduction per cycle) -> DONE.
// Optional feature macro: MDC_CYCLE_CNT_EN adds cyc_o, the CALC-cycle count
// of the most recent computation.
module mdc_engine
    import mdc_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             enb_i,
    input  logic [WIDTH-1:0] dtx_i,
    input  logic [WIDTH-1:0] dty_i,
    output logic             busy_o,
    output logic             done_o,
`ifdef MDC_CYCLE_CNT_EN
    output logic [$clog2(calc_bound(WIDTH)+1)-1:0] cyc_o,
`endif
    output logic [WIDTH-1:0] dt_o
);

    localparam int KW = $clog2(WIDTH + 1);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] x, y, x_nxt, y_nxt;
    logic [KW-1:0]    k, k_nxt;
    logic             eq;
    logic             capture;
    logic             zero_op;

    assign capture = (state == IDLE) && enb_i;
    assign zero_op = (dtx_i == '0) || (dty_i == '0);

    mdc_step #(.WIDTH(WIDTH), .KW(KW)) u_step (
        .x     (x),
        .y     (y),
        .k     (k),
        .x_nxt (x_nxt),
        .y_nxt (y_nxt),
        .k_nxt (k_nxt),
        .eq    (eq)
    );

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state and status outputs; enb_i only matters in IDLE.
    always_comb begin
        state_nxt = state;
        busy_o    = 1'b0;
        done_o    = 1'b0;
        case (state)
            IDLE: if (enb_i) state_nxt = zero_op ? DONE : CALC;
            CALC: begin
                busy_o = 1'b1;
                if (eq) state_nxt = DONE;
            end
            DONE: begin
                done_o    = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand/shift registers and the held result.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            x    <= '0;
            y    <= '0;
            k    <= '0;
            dt_o <= '0;
        end else if (capture) begin
            x <= dtx_i;
            y <= dty_i;
            k <= '0;
            // gcd(a,0) = a and gcd(0,0) = 0 both fall out of a plain OR
            if (zero_op) dt_o <= dtx_i | dty_i;
        end else if (state == CALC) begin
            if (eq) begin
                // result never exceeds the larger operand, so no bits are lost
                dt_o <= x << k;
            end else begin
                x <= x_nxt;
                y <= y_nxt;
                k <= k_nxt;
            end
        end
    end

`ifdef MDC_CYCLE_CNT_EN
    localparam int CW = $clog2(calc_bound(WIDTH) + 1);

    // CALC-cycle counter: cleared on capture, held outside CALC.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)               cyc_o <= '0;
        else if (capture)        cyc_o <= '0;
        else if (state == CALC)  cyc_o <= cyc_o + CW'(1);
    end
`endif

endmodule

// File: tb/tb_mdc_engine.sv
// Directed bench for mdc_engine at WIDTH=8 and WIDTH=16.
module tb_mdc_engine;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enb8 = 1'b0, enb16 = 1'b0;
    logic [7:0]  dtx8 = '0, dty8 = '0, dt8;
    logic [15:0] dtx16 = '0, dty16 = '0, dt16;
    logic        busy8, done8, busy16, done16;
`ifdef MDC_CYCLE_CNT_EN
    logic [4:0]  cyc8;
    logic [5:0]  cyc16;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mdc_engine #(.WIDTH(8)) u8 (
        .clk_i(clk), .rst_i(rst), .enb_i(enb8), .dtx_i(dtx8), .dty_i(dty8),
        .busy_o(busy8), .done_o(done8),
`ifdef MDC_CYCLE_CNT_EN
        .cyc_o(cyc8),
`endif
        .dt_o(dt8)
    );

    mdc_engine #(.WIDTH(16)) u16 (
        .clk_i(clk), .rst_i(rst), .enb_i(enb16), .dtx_i(dtx16), .dty_i(dty16),
        .busy_o(busy16), .done_o(done16),
`ifdef MDC_CYCLE_CNT_EN
        .cyc_o(cyc16),
`endif
        .dt_o(dt16)
    );

    function automatic int gcd_ref(input int a, input int b);
        int t;
        while (b != 0) begin
            t = a % b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    // Start one 8-bit computation and return at the negedge where done is seen.
    // lat = negedges waited after capture, busy_n = negedges with busy high.
    task automatic run8(input logic [7:0] a, input logic [7:0] b,
                        output int lat, output int busy_n, output bit tmo);
        @(negedge clk);
        dtx8 = a; dty8 = b; enb8 = 1'b1;
        @(negedge clk);
        enb8 = 1'b0; dtx8 = 8'($urandom); dty8 = 8'($urandom);
        lat = 0; busy_n = 0; tmo = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (done8) begin tmo = 1'b0; break; end
            if (busy8) busy_n++;
            lat++;
            @(negedge clk);
        end
    endtask

    task automatic run16(input logic [15:0] a, input logic [15:0] b,
                         output int busy_n, output bit tmo);
        @(negedge clk);
        dtx16 = a; dty16 = b; enb16 = 1'b1;
        @(negedge clk);
        enb16 = 1'b0; dtx16 = 16'($urandom); dty16 = 16'($urandom);
        busy_n = 0; tmo = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (done16) begin tmo = 1'b0; break; end
            if (busy16) busy_n++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        #12;
        n_checks++;
        if ({busy8, done8, dt8} !== 10'd0) begin
            n_fail++; $display("FAIL reset8: busy=%b done=%b dt=%0d, required all 0", busy8, done8, dt8);
        end
        n_checks++;
        if ({busy16, done16, dt16} !== 18'd0) begin
            n_fail++; $display("FAIL reset16: busy=%b done=%b dt=%0d, required all 0", busy16, done16, dt16);
        end
`ifdef MDC_CYCLE_CNT_EN
        n_checks++;
        if (cyc8 !== 5'd0) begin n_fail++; $display("FAIL reset_cyc: got %0d required 0", cyc8); end
`endif
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic();
        int lat, bn; bit tmo;
        run8(8'd48, 8'd18, lat, bn, tmo);
        n_checks++;
        if (tmo || dt8 !== 8'd6) begin n_fail++; $display("FAIL basic_dt: got %0d required 6 (tmo=%0b)", dt8, tmo); end
        n_checks++;
        if (lat != 6) begin n_fail++; $display("FAIL basic_latency: got %0d required 6", lat); end
        n_checks++;
        if (bn != 6) begin n_fail++; $display("FAIL basic_busy: got %0d required 6", bn); end
        n_checks++;
        if (busy8 !== 1'b0) begin n_fail++; $display("FAIL basic_busy_in_done: got %b required 0", busy8); end
`ifdef MDC_CYCLE_CNT_EN
        n_checks++;
        if (cyc8 !== 5'd6) begin n_fail++; $display("FAIL basic_cyc: got %0d required 6", cyc8); end
`endif
        @(negedge clk);
        n_checks++;
        if (done8 !== 1'b0 || dt8 !== 8'd6) begin
            n_fail++; $display("FAIL basic_after: done=%b dt=%0d required done=0 dt=6", done8, dt8);
        end
    endtask

    task automatic test_zero();
        int lat, bn; bit tmo;
        run8(8'd0, 8'd25, lat, bn, tmo);
        n_checks++;
        if (tmo || lat != 0 || bn != 0) begin
            n_fail++; $display("FAIL zero_timing: lat=%0d busy=%0d required 0/0", lat, bn);
        end
        n_checks++;
        if (dt8 !== 8'd25) begin n_fail++; $display("FAIL zero_dt: got %0d required 25", dt8); end
`ifdef MDC_CYCLE_CNT_EN
        n_checks++;
        if (cyc8 !== 5'd0) begin n_fail++; $display("FAIL zero_cyc: got %0d required 0", cyc8); end
`endif
        run8(8'd0, 8'd0, lat, bn, tmo);
        n_checks++;
        if (tmo || lat != 0 || dt8 !== 8'd0) begin
            n_fail++; $display("FAIL zero_zero: dt=%0d lat=%0d required dt=0 lat=0", dt8, lat);
        end
    endtask

    task automatic test_edges();
        int lat, bn; bit tmo;
        run8(8'd7, 8'd7, lat, bn, tmo);
        n_checks++;
        if (tmo || bn != 1 || dt8 !== 8'd7) begin
            n_fail++; $display("FAIL equal_ops: dt=%0d calc=%0d required dt=7 calc=1", dt8, bn);
        end
        run8(8'd255, 8'd1, lat, bn, tmo);
        n_checks++;
        if (tmo || bn != 8 || dt8 !== 8'd1) begin
            n_fail++; $display("FAIL max_min: dt=%0d calc=%0d required dt=1 calc=8", dt8, bn);
        end
`ifdef MDC_CYCLE_CNT_EN
        n_checks++;
        if (cyc8 !== 5'd8) begin n_fail++; $display("FAIL max_min_cyc: got %0d required 8", cyc8); end
`endif
    endtask

    task automatic test_held_enable();
        int bn; bit tmo;
        @(negedge clk);
        dtx8 = 8'd48; dty8 = 8'd18; enb8 = 1'b1;
        bn = 0; tmo = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            dtx8 = 8'($urandom_range(255, 1)); dty8 = 8'($urandom_range(255, 1));
            if (done8) begin tmo = 1'b0; break; end
            if (busy8) bn++;
        end
        n_checks++;
        if (tmo || dt8 !== 8'd6 || bn != 6) begin
            n_fail++; $display("FAIL held_en: dt=%0d calc=%0d required dt=6 calc=6", dt8, bn);
        end
        // IDLE cycle after DONE: enb still high, so this edge starts 12/8
        dtx8 = 8'd12; dty8 = 8'd8;
        @(negedge clk);
        n_checks++;
        if (busy8 !== 1'b0 || done8 !== 1'b0) begin
            n_fail++; $display("FAIL held_idle: busy=%b done=%b required 0/0", busy8, done8);
        end
        @(negedge clk);
        enb8 = 1'b0;
        n_checks++;
        if (busy8 !== 1'b1) begin n_fail++; $display("FAIL held_restart: busy=%b required 1", busy8); end
        tmo = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (done8) begin tmo = 1'b0; break; end
            @(negedge clk);
        end
        n_checks++;
        if (tmo || dt8 !== 8'd4) begin n_fail++; $display("FAIL held_second: dt=%0d required 4", dt8); end
    endtask

    task automatic test_abort();
        int lat, bn; bit tmo;
        @(negedge clk);
        dtx8 = 8'd48; dty8 = 8'd18; enb8 = 1'b1;
        @(negedge clk);
        enb8 = 1'b0;
        @(negedge clk);
        @(negedge clk);   // third CALC cycle
        n_checks++;
        if (busy8 !== 1'b1) begin n_fail++; $display("FAIL abort_pre: busy=%b required 1", busy8); end
        rst = 1'b1;
        #1;
        n_checks++;
        if (busy8 !== 1'b0 || done8 !== 1'b0 || dt8 !== 8'd0) begin
            n_fail++; $display("FAIL abort_rst: busy=%b done=%b dt=%0d required 0/0/0", busy8, done8, dt8);
        end
`ifdef MDC_CYCLE_CNT_EN
        n_checks++;
        if (cyc8 !== 5'd0) begin n_fail++; $display("FAIL abort_cyc: got %0d required 0", cyc8); end
`endif
        @(negedge clk);
        rst = 1'b0;
        run8(8'd12, 8'd8, lat, bn, tmo);
        n_checks++;
        if (tmo || dt8 !== 8'd4 || bn != 5) begin
            n_fail++; $display("FAIL abort_fresh: dt=%0d calc=%0d required dt=4 calc=5", dt8, bn);
        end
    endtask

    task automatic test_random16();
        int bn; bit tmo;
        logic [15:0] a, b;
        int exp;
        for (int n = 0; n < 20; n++) begin
            a = 16'($urandom_range(65535, 1));
            b = (n % 5 == 0) ? 16'(a * 3 / 2 + 2) : 16'($urandom_range(65535, 1));
            if (n == 7) begin a = 16'd65535; b = 16'd1; end
            if (n == 8) begin a = 16'd32768; b = 16'd49152; end
            exp = gcd_ref(int'(a), int'(b));
            run16(a, b, bn, tmo);
            n_checks++;
            if (tmo || dt16 !== 16'(exp) || bn > 32) begin
                n_fail++;
                $display("FAIL rand16 %0d/%0d: dt=%0d calc=%0d required dt=%0d calc<=32", a, b, dt16, bn, exp);
            end
            @(negedge clk);
            n_checks++;
            if (done16 !== 1'b0) begin n_fail++; $display("FAIL rand16_pulse: done=%b required 0", done16); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero();
        test_edges();
        test_held_enable();
        test_abort();
        test_random16();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mdc_engine.md
MDC_ENGINE -- requirements
Module: mdc_engine

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, operand/result width in bits (legal range 2..32).
REQ-002 The block SHALL have port clk_i, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_i, input, 1 bit, asynchronous active-high reset.
REQ-004 The block SHALL have port enb_i, input, 1 bit, start request sampled on the rising edge.
REQ-005 The block SHALL have ports dtx_i and dty_i, each input, WIDTH bits, unsigned operands.
REQ-006 The block SHALL have port busy_o, output, 1 bit, high while in CALC.
REQ-007 The block SHALL have port done_o, output, 1 bit, one-cycle result-valid pulse.
REQ-008 The block SHALL have port dt_o, output, WIDTH bits, greatest common divisor result.

Function
REQ-009 The block SHALL have FSM states IDLE, CALC and DONE.
REQ-010 IDLE: enb_i high SHALL capture dtx_i/dty_i into x/y, clear shift count k, and go to CALC; enb_i is ignored in CALC and DONE.
REQ-011 Capture with x==0 or y==0 SHALL go directly to DONE with dt_o = x|y (gcd(0,0)=0).
REQ-012 Each CALC cycle SHALL apply exactly one rule, in priority order: x==y -> dt_o = x<<k, go DONE; both even -> x>>=1, y>>=1, k++; x even -> x>>=1; y even -> y>>=1; both odd -> larger := (larger-smaller)>>1.
REQ-013 k SHALL be $clog2(WIDTH+1) bits wide; x<<k SHALL never overflow WIDTH bits, since the result is at most max(dtx_i,dty_i).
REQ-014 CALC SHALL last no more than 2*WIDTH cycles for any operand pair.
REQ-015 DONE SHALL last one cycle with done_o=1 and busy_o=0, then return to IDLE.
REQ-016 dt_o SHALL hold its value from DONE until the next DONE.
REQ-017 busy_o SHALL be 1 exactly in CALC, and done_o SHALL be 1 exactly in DONE.
REQ-018 Operand inputs SHALL be don't-care outside the capture edge.

Reset
REQ-019 Asserting rst_i SHALL immediately force IDLE, with busy_o=0, done_o=0, dt_o=0, x=y=0 and k=0, including mid-CALC.
REQ-020 After reset deasserts, the first enb_i SHALL start a fresh computation with no residue from an aborted one.

Configuration
REQ-021 With macro MDC_CYCLE_CNT_EN defined, the block SHALL add output cyc_o, $clog2(2*WIDTH+1) bits, holding the CALC-cycle count of the last computation.
REQ-022 cyc_o SHALL be cleared on capture, increment once per CALC cycle, hold from DONE until the next capture, and reset to 0.
REQ-023 Without MDC_CYCLE_CNT_EN, neither the port nor the counter SHALL exist, and all other behaviour SHALL be identical.

Structure
REQ-024 Package mdc_pkg SHALL hold the FSM state enum typedef and the CALC-bound constant function (2*WIDTH).
REQ-025 The single-iteration combinational datapath (REQ-012 rules producing next x, y and k plus an equal flag) SHALL be sub-module mdc_step; mdc_engine holds the FSM and registers.

Verification
REQ-026 The bench SHALL run WIDTH=8 with operands 48 and 18 and require dt_o=6, done_o after 6 CALC cycles, busy_o high for exactly 6 cycles, and cyc_o=6.
REQ-027 The bench SHALL run WIDTH=8 with operands 0 and 25 and require DONE on the cycle after capture, busy_o never high, dt_o=25, and cyc_o=0; then run 0 and 0 and require dt_o=0.
REQ-028 The bench SHALL run WIDTH=8 with operands 7 and 7, requiring 1 CALC cycle and dt_o=7; and 255 and 1, requiring 8 CALC cycles and dt_o=1.
REQ-029 The bench SHALL hold enb_i high throughout a 48/18 run with changing operands and require only the initial capture to be used, dt_o=6, and a new start in the cycle after DONE.
REQ-030 The bench SHALL assert rst_i in the 3rd CALC cycle of 48/18 and require busy_o=0 and dt_o=0 immediately; after release, 12 and 8 SHALL yield dt_o=4.
REQ-031 The bench SHALL run WIDTH=16 with random operand pairs against a reference model and require a matching result, CALC of at most 32 cycles, and done_o as a single-cycle pulse.
